fb_scan_arbiter: RTL and testbench

Shares one single-port synchronous framebuffer RAM (8-bit RRRGGGBB per pixel) between two requesters: the VGA scanout path and a pixel-write requester such as a drawing engine or host port. Scanout reads are prefetched into a small pixel FIFO that the VGA colour path drains one pixel per active-display cycle. The block sits between the 25 MHz pixel-clock domain logic (vga_driver colour input) and the framebuffer RAM, and guarantees scanout priority whenever the prefetch level is low.

---
 rtl/fb_pkg.sv | 18 +
 rtl/pix_fifo.sv | 52 +++++
 rtl/fb_scan_arbiter.sv | 106 ++++++++++
 tb/tb_fb_scan_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry, pixel format and arbitration types shared by the scanout path.
// Declarations only: no latency, no flow control.
package fb_pkg;
  localparam int FB_W = 320;
  localparam int FB_H = 240;
  localparam int NPIX = FB_W * FB_H;
  localparam int AW   = 17;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic { SCAN = 1'b0, WRITE = 1'b1 } grant_e;

  typedef enum logic [1:0] { OP_IDLE, OP_FLUSH, OP_READ, OP_WRITE } op_e;
endpackage

// File: rtl/pix_fifo.sv
// Pixel prefetch FIFO: push visible at head/count next cycle; flush beats push and pop.
// No backpressure: pushes when full and pops when empty are ignored, the caller keeps it in range.
module pix_fifo import fb_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  rgb332_t       push_dat,
  input  logic          pop_i,
  output rgb332_t       head_dat,
  output logic [CW-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  rgb332_t       mem [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop_i && (count != '0);
  assign do_push  = push_i && (count != FULL);
  assign head_dat = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem[wptr] <= push_dat;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/fb_scan_arbiter.sv
// Shares one framebuffer RAM port between scanout prefetch and a pixel writer; read data lands in the FIFO 3 cycles after the grant.
// Writer holds wr_req_i until wr_gnt_o; scanout wins outright below LOW_WM, otherwise slots alternate.
module fb_scan_arbiter import fb_pkg::*; #(
  parameter int DEPTH  = 8,
  parameter int LOW_WM = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          frame_start_i,
  input  logic          pix_rd_i,
  output logic [7:0]    pix_o,
  output logic          pix_valid_o,
  output logic          underrun_o,
  input  logic          wr_req_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [7:0]    wr_data_i,
  output logic          wr_gnt_o,
  output logic [AW-1:0] mem_addr_o,
  output logic          mem_we_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int LW = CW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] LOW_L   = LW'(LOW_WM);
  localparam logic [AW:0]   NPIX_L  = (AW+1)'(NPIX);

  logic [AW:0]   scan_addr;
  logic          armed;
  logic          rd_p1;
  logic          rd_p2;
  grant_e        last_grant;
  op_e           op;
  logic [CW-1:0] fifo_count;
  rgb332_t       head;
  logic [LW-1:0] level;
  logic          scan_want;
  logic          fifo_empty;

  // Reads in flight count against the FIFO so a full pipeline can never overflow it.
  assign level      = LW'(fifo_count) + LW'(rd_p1) + LW'(rd_p2);
  // Scanout stays idle after reset until the first frame_start_i gives it a frame to fetch.
  assign scan_want  = armed && (level < DEPTH_L) && (scan_addr < NPIX_L);
  assign fifo_empty = (fifo_count == '0);

  always_comb begin
    op = OP_IDLE;
    if (frame_start_i)                                  op = OP_FLUSH;
    else if (scan_want && (level < LOW_L || !wr_req_i)) op = OP_READ;
    else if (wr_req_i && scan_want)                     op = (last_grant == SCAN) ? OP_WRITE : OP_READ;
    else if (wr_req_i)                                  op = OP_WRITE;
  end

  assign wr_gnt_o    = (op == OP_WRITE) && !rst_i;
  assign pix_valid_o = !fifo_empty;
  assign pix_o       = fifo_empty ? 8'h00 : head;
  assign underrun_o  = pix_rd_i && fifo_empty && !frame_start_i && !rst_i;

  pix_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (frame_start_i),
    .push_i   (rd_p2),
    .push_dat (mem_rdata_i),
    .pop_i    (pix_rd_i && !frame_start_i),
    .head_dat (head),
    .count    (fifo_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scan_addr   <= '0;
      armed       <= 1'b0;
      rd_p1       <= 1'b0;
      rd_p2       <= 1'b0;
      last_grant  <= SCAN;
      mem_addr_o  <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
    end else begin
      // Clearing the in-flight tags on a flush drops returns that belong to the old frame.
      rd_p1    <= (op == OP_READ);
      rd_p2    <= rd_p1 && !frame_start_i;
      mem_we_o <= 1'b0;
      case (op)
        OP_FLUSH: begin
          scan_addr <= '0;
          armed     <= 1'b1;
        end
        OP_READ: begin
          mem_addr_o <= scan_addr[AW-1:0];
          scan_addr  <= scan_addr + (AW+1)'(1);
          last_grant <= SCAN;
        end
        OP_WRITE: begin
          mem_addr_o  <= wr_addr_i;
          mem_wdata_o <= wr_data_i;
          mem_we_o    <= 1'b1;
          last_grant  <= WRITE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Directed bench for fb_scan_arbiter with a behavioural single-port RAM holding RAM[i] = i[7:0] until written.
module tb_fb_scan_arbiter;
  import fb_pkg::*;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          frame_start_i;
  logic          pix_rd_i;
  logic [7:0]    pix_o;
  logic          pix_valid_o;
  logic          underrun_o;
  logic          wr_req_i;
  logic [AW-1:0] wr_addr_i;
  logic [7:0]    wr_data_i;
  logic          wr_gnt_o;
  logic [AW-1:0] mem_addr_o;
  logic          mem_we_o;
  logic [7:0]    mem_wdata_o;
  logic [7:0]    mem_rdata_i = 8'h00;

  int vec  = 0;
  int errs = 0;
  int nw   = 0;

  logic [7:0]    wr_map [int];
  logic [AW-1:0] wa [6] = '{17'h1FFFF, 17'h00010, 17'h00020, 17'h00030, 17'h00040, 17'h00050};
  logic [7:0]    wd [6] = '{8'h5A, 8'hC3, 8'h11, 8'h22, 8'h33, 8'h44};

  fb_scan_arbiter dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .frame_start_i (frame_start_i),
    .pix_rd_i      (pix_rd_i),
    .pix_o         (pix_o),
    .pix_valid_o   (pix_valid_o),
    .underrun_o    (underrun_o),
    .wr_req_i      (wr_req_i),
    .wr_addr_i     (wr_addr_i),
    .wr_data_i     (wr_data_i),
    .wr_gnt_o      (wr_gnt_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_wdata_o   (mem_wdata_o),
    .mem_rdata_i   (mem_rdata_i)
  );

  always #20 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    int a;
    a = int'(mem_addr_o);
    mem_rdata_i <= wr_map.exists(a) ? wr_map[a] : 8'(a);
    if (mem_we_o) wr_map[a] = mem_wdata_o;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    @(negedge clk_i);
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i = 1'b1; frame_start_i = 1'b0; pix_rd_i = 1'b0;
    wr_req_i = 1'b0; wr_addr_i = '0; wr_data_i = '0;
    adv(); adv();
    chk("rst_pix",    32'(pix_o), 32'h0);
    chk("rst_valid",  32'(pix_valid_o), 32'h0);
    chk("rst_under",  32'(underrun_o), 32'h0);
    chk("rst_gnt",    32'(wr_gnt_o), 32'h0);
    chk("rst_addr",   32'(mem_addr_o), 32'h0);
    chk("rst_we",     32'(mem_we_o), 32'h0);
    chk("rst_wdata",  32'(mem_wdata_o), 32'h0);
    rst_i = 1'b0;

    // Idle before the first frame: no scanout reads.
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("pre_addr",  32'(mem_addr_o), 32'h0);
      chk("pre_valid", 32'(pix_valid_o), 32'h0);
      adv();
    end

    // Frame start with no writes: eight back-to-back reads, then the FIFO sits full.
    frame_start_i = 1'b1;
    settle();
    chk("fs_gnt", 32'(wr_gnt_o), 32'h0);
    adv();
    frame_start_i = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      settle();
      chk("fill_addr",  32'(mem_addr_o), (k < 2) ? 32'd0 : ((k - 2 > 7) ? 32'd7 : 32'(k - 2)));
      chk("fill_valid", 32'(pix_valid_o), 32'(k >= 4));
      chk("fill_we",    32'(mem_we_o), 32'h0);
      adv();
    end

    // Continuous drain of 1000 pixels.
    for (int j = 0; j < 1000; j++) begin
      pix_rd_i = 1'b1;
      settle();
      chk("drain_pix",   32'(pix_o), 32'(j & 255));
      chk("drain_under", 32'(underrun_o), 32'h0);
      adv();
    end
    pix_rd_i = 1'b0;
    repeat (12) adv();

    // Writer held high with a draining, well-filled FIFO: slots alternate WRITE/READ.
    for (int c = 0; c <= 8; c++) begin
      wr_req_i = 1'b1; wr_addr_i = wa[nw]; wr_data_i = wd[nw]; pix_rd_i = 1'b1;
      settle();
      chk("alt_gnt", 32'(wr_gnt_o), 32'(c % 2 == 0));
      chk("alt_pix", 32'(pix_o), 32'((1000 + c) & 255));
      if (c > 0) begin
        if (c % 2 == 1) begin
          chk("alt_we",    32'(mem_we_o), 32'h1);
          chk("alt_waddr", 32'(mem_addr_o), 32'(wa[nw-1]));
          chk("alt_wdata", 32'(mem_wdata_o), 32'(wd[nw-1]));
        end else begin
          chk("alt_rwe",   32'(mem_we_o), 32'h0);
          chk("alt_raddr", 32'(mem_addr_o), 32'(1008 + c / 2 - 1));
        end
      end
      adv();
      if (c % 2 == 0) nw++;
    end
    wr_req_i = 1'b0; pix_rd_i = 1'b0;
    settle();
    chk("alt_we_last",    32'(mem_we_o), 32'h1);
    chk("alt_waddr_last", 32'(mem_addr_o), 32'(wa[4]));
    chk("alt_wdata_last", 32'(mem_wdata_o), 32'(wd[4]));
    adv();
    settle();
    adv();

    // Flush with two reads in flight, writer waiting: reads restart at 0, writer waits for level 4.
    frame_start_i = 1'b1; wr_req_i = 1'b1; wr_addr_i = wa[5]; wr_data_i = wd[5];
    settle();
    chk("fl_gnt",  32'(wr_gnt_o), 32'h0);
    chk("fl_addr", 32'(mem_addr_o), 32'd1013);
    adv();
    frame_start_i = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      settle();
      chk("lw_gnt",   32'(wr_gnt_o), 32'(k == 5));
      chk("lw_valid", 32'(pix_valid_o), 32'(k >= 4));
      if (k == 6) begin
        chk("lw_we",    32'(mem_we_o), 32'h1);
        chk("lw_waddr", 32'(mem_addr_o), 32'(wa[5]));
        chk("lw_wdata", 32'(mem_wdata_o), 32'(wd[5]));
      end else begin
        chk("lw_addr", 32'(mem_addr_o), (k == 1) ? 32'd1013 : 32'(k - 2));
      end
      adv();
      if (k == 5) wr_req_i = 1'b0;
    end

    // Underrun on an empty FIFO, then frame start coincident with a read request.
    frame_start_i = 1'b1;
    settle();
    adv();
    frame_start_i = 1'b0; pix_rd_i = 1'b1;
    settle();
    chk("ur_pulse", 32'(underrun_o), 32'h1);
    chk("ur_pix",   32'(pix_o), 32'h0);
    chk("ur_valid", 32'(pix_valid_o), 32'h0);
    adv();
    frame_start_i = 1'b1;
    settle();
    chk("ur_fs", 32'(underrun_o), 32'h0);
    adv();
    frame_start_i = 1'b0; pix_rd_i = 1'b0;

    // Asynchronous reset in the middle of a fetch burst.
    repeat (3) begin
      settle();
      adv();
    end
    settle();
    chk("mid_addr",  32'(mem_addr_o), 32'd2);
    chk("mid_valid", 32'(pix_valid_o), 32'h1);
    chk("mid_wdata", 32'(mem_wdata_o), 32'h44);
    #5;
    rst_i = 1'b1;
    #1;
    chk("ar_addr",  32'(mem_addr_o), 32'h0);
    chk("ar_valid", 32'(pix_valid_o), 32'h0);
    chk("ar_we",    32'(mem_we_o), 32'h0);
    chk("ar_wdata", 32'(mem_wdata_o), 32'h0);
    chk("ar_pix",   32'(pix_o), 32'h0);
    adv();
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("post_addr",  32'(mem_addr_o), 32'h0);
      chk("post_valid", 32'(pix_valid_o), 32'h0);
      adv();
    end
    frame_start_i = 1'b1;
    settle();
    adv();
    frame_start_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      settle();
      chk("re_addr",  32'(mem_addr_o), (k < 2) ? 32'd0 : 32'(k - 2));
      chk("re_valid", 32'(pix_valid_o), 32'(k >= 4));
      adv();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
